// File: rtl/unified_buffer.sv
// unified_buffer: banked, low-order interleaved SRAM shared by a DMA port and NB PE ports
module unified_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NB     = 4
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dma_write_en,
  input  logic                          dma_read_en,
  input  logic [ADDR_W-1:0]             dma_addr,
  input  logic [DATA_W-1:0]             dma_data_in,
  output logic [DATA_W-1:0]             dma_data_out,
  input  logic [NB-1:0]                 pe_read_en,
  input  logic [NB-1:0]                 pe_write_en,
  input  logic [NB-1:0][ADDR_W-1:0]     pe_addr,
  input  logic [NB-1:0][DATA_W-1:0]     pe_data_in,
  output logic [NB-1:0][DATA_W-1:0]     pe_data_out
);
  localparam int BANK_BITS = $clog2(NB);
  localparam int ROW_W     = ADDR_W - BANK_BITS;
  logic [BANK_BITS-1:0] dma_bank, sel_q;
  logic [ROW_W-1:0]     dma_row;
  logic [DATA_W-1:0]    dq [NB];
  logic [DATA_W-1:0]    po [NB];
  assign dma_bank     = dma_addr[BANK_BITS-1:0];
  assign dma_row      = dma_addr[ADDR_W-1:BANK_BITS];
  assign dma_data_out = dq[sel_q];
  always_ff @(posedge clk or posedge reset)
    if (reset) sel_q <= '0;
    else if (dma_read_en) sel_q <= dma_bank;
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DATA_W-1:0] mem [2**ROW_W];
    logic              dw, dr;
    logic [ROW_W-1:0]  pe_row, wrow, rrow;
    always_comb begin
      dw     = dma_write_en && dma_bank == BANK_BITS'(b);
      dr     = dma_read_en && dma_bank == BANK_BITS'(b);
      pe_row = pe_addr[b][ADDR_W-1:BANK_BITS];
      wrow   = dw ? dma_row : pe_row;
      rrow   = dr ? dma_row : pe_row;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        dq[b] <= '0;
        po[b] <= '0;
      end else begin
        if (dw || pe_write_en[b]) mem[wrow] <= dw ? dma_data_in : pe_data_in[b];
        if (dr) dq[b] <= mem[rrow];
        else if (pe_read_en[b]) po[b] <= mem[rrow];
      end
    assign pe_data_out[b] = po[b];
  end
endmodule

// File: tb/tb_unified_buffer.sv
// tb_unified_buffer: scoreboard bench for unified_buffer
module tb_unified_buffer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int NB     = 4;
  logic                      clk = 0;
  logic                      reset;
  logic                      dma_write_en, dma_read_en;
  logic [ADDR_W-1:0]         dma_addr;
  logic [DATA_W-1:0]         dma_data_in, dma_data_out;
  logic [NB-1:0]             pe_read_en, pe_write_en;
  logic [NB-1:0][ADDR_W-1:0] pe_addr;
  logic [NB-1:0][DATA_W-1:0] pe_data_in, pe_data_out;
  logic [DATA_W-1:0]         dq [$];
  logic [DATA_W-1:0]         pq [NB][$];
  logic                      dv = 0;
  logic [NB-1:0]             pv = '0;
  int                        tests = 0, fails = 0;
  unified_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NB(NB)) dut (
    .clk(clk), .reset(reset),
    .dma_write_en(dma_write_en), .dma_read_en(dma_read_en), .dma_addr(dma_addr),
    .dma_data_in(dma_data_in), .dma_data_out(dma_data_out),
    .pe_read_en(pe_read_en), .pe_write_en(pe_write_en), .pe_addr(pe_addr),
    .pe_data_in(pe_data_in), .pe_data_out(pe_data_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    dma_write_en = 0;
    dma_read_en  = 0;
    pe_read_en   = '0;
    pe_write_en  = '0;
  endtask
  always @(posedge clk) begin
    dv <= dma_read_en && !reset;
    pv <= reset ? '0 : pe_read_en;
  end
  always @(negedge clk) begin
    if (dv) begin
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dma_unexpected got %h expected none", dma_data_out);
      end else chk("dma_rd", dma_data_out, dq.pop_front());
    end
    for (int j = 0; j < NB; j++)
      if (pv[j]) begin
        if (pq[j].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pe%0d_unexpected got %h expected none", j, pe_data_out[j]);
        end else chk($sformatf("pe%0d_rd", j), pe_data_out[j], pq[j].pop_front());
      end
  end
  initial begin
    reset = 1;
    idle();
    dma_addr = '0;
    dma_data_in = '0;
    pe_addr = '0;
    pe_data_in = '0;
    repeat (2) step();
    chk("reset_dma", dma_data_out, 32'h0);
    for (int j = 0; j < NB; j++) chk($sformatf("reset_pe%0d", j), pe_data_out[j], 32'h0);
    reset = 0;
    step();
    for (int i = 0; i < 16; i++) begin
      dma_write_en = 1;
      dma_addr = ADDR_W'(i);
      dma_data_in = 32'hDEAD0000 + i;
      step();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      dma_read_en = 1;
      dma_addr = ADDR_W'(i);
      dq.push_back(32'hDEAD0000 + i);
      step();
    end
    idle();
    pe_write_en = '1;
    for (int j = 0; j < NB; j++) begin
      pe_addr[j] = ADDR_W'(10'h100 + j);
      pe_data_in[j] = 32'hBEEF0000 + j;
    end
    for (int k = 0; k < 8; k++) begin
      dma_read_en = 1;
      dma_addr = ADDR_W'(k);
      dq.push_back(32'hDEAD0000 + k);
      step();
      pe_write_en = '0;
    end
    idle();
    pe_read_en = '1;
    for (int j = 0; j < NB; j++) pq[j].push_back(32'hBEEF0000 + j);
    step();
    pe_read_en = 4'b0010;
    pe_addr[1] = 10'h100;
    pq[1].push_back(32'hBEEF0001);
    step();
    idle();
    for (int i = 4; i < 8; i++) begin
      dma_write_en = 1;
      dma_addr = ADDR_W'(i);
      dma_data_in = 32'hABCD1000 + i;
      step();
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      dma_read_en = 1;
      dma_addr = ADDR_W'(k);
      dq.push_back(k < 4 ? 32'hDEAD0000 + k : 32'hABCD1000 + k);
      step();
    end
    idle();
    dma_write_en = 1;
    dma_read_en = 1;
    dma_addr = 10'h001;
    dma_data_in = 32'h55555555;
    dq.push_back(32'hDEAD0001);
    step();
    dma_write_en = 0;
    dq.push_back(32'h55555555);
    step();
    idle();
    dma_write_en = 1;
    dma_addr = 10'h200;
    dma_data_in = 32'h11111111;
    pe_write_en = 4'b0001;
    pe_addr[0] = 10'h200;
    pe_data_in[0] = 32'h22222222;
    step();
    idle();
    dma_read_en = 1;
    dq.push_back(32'h11111111);
    step();
    idle();
    pe_read_en = 4'b0001;
    pq[0].push_back(32'h11111111);
    step();
    dma_read_en = 1;
    dma_addr = 10'h004;
    dq.push_back(32'hABCD1004);
    pe_addr[0] = 10'h100;
    pq[0].push_back(32'h11111111);
    step();
    idle();
    dma_read_en = 1;
    dma_addr = 10'h008;
    dq.push_back(32'hDEAD0008);
    pe_write_en = 4'b0001;
    pe_addr[0] = 10'h300;
    pe_data_in[0] = 32'h33333333;
    step();
    idle();
    pe_read_en = 4'b0001;
    pq[0].push_back(32'h33333333);
    step();
    idle();
    repeat (2) step();
    chk("dma_hold", dma_data_out, 32'hDEAD0008);
    chk("pe0_hold", pe_data_out[0], 32'h33333333);
    dma_read_en = 1;
    dma_addr = 10'h001;
    dma_write_en = 1;
    dma_data_in = 32'hFFFFFFFF;
    dma_addr = 10'h002;
    reset = 1;
    #1;
    chk("midreset_dma", dma_data_out, 32'h0);
    chk("midreset_pe0", pe_data_out[0], 32'h0);
    repeat (2) step();
    chk("reset_held_dma", dma_data_out, 32'h0);
    idle();
    reset = 0;
    step();
    dma_read_en = 1;
    dma_addr = 10'h002;
    dq.push_back(32'hDEAD0002);
    pe_read_en = 4'b0001;
    pe_addr[0] = 10'h300;
    pq[0].push_back(32'h33333333);
    step();
    idle();
    for (int t = 0; t < 20 && (dq.size() != 0 || pq[0].size() != 0 || pq[1].size() != 0
         || pq[2].size() != 0 || pq[3].size() != 0); t++) step();
    step();
    tests++;
    if (dq.size() != 0) begin
      fails++;
      $display("FAIL dma_drain got %0d pending expected 0", dq.size());
    end
    for (int j = 0; j < NB; j++) begin
      tests++;
      if (pq[j].size() != 0) begin
        fails++;
        $display("FAIL pe%0d_drain got %0d pending expected 0", j, pq[j].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
